stream_framer: RTL and testbench

- Parametrised, single-clock successor to the FT stream encoder.
- Buffers an incoming word stream in an internal FIFO and emits fixed-length packets with a header: sync word, sequence number and payload length.
- Output side presents a show-ahead FIFO read interface (readreq/empty/data) to the FT transmit path.
- A flush input closes a short packet so a partial buffer can be drained at end of scan.

---
 rtl/stream_framer.sv | 165 ++++++++++++++++
 tb/tb_stream_framer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_framer.sv
// stream_framer: buffers an rx word stream and emits sync/seq/len-headed packets on a show-ahead tx port.
// Optional CRC-16-CCITT trailer word is compiled in when STREAM_FRAMER_CRC_EN is defined.
module stream_framer #(
   parameter int          DATA_W    = 16,
   parameter int          DEPTH     = 512,
   parameter int          PKT_WORDS = 256,
   parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_full,
   input  logic              rx_flush,
   input  logic              tx_readreq,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_empty,
   output logic [15:0]       ovf_count,
   output logic [DATA_W-1:0] seq
);
   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);

`ifdef STREAM_FRAMER_CRC_EN
   typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_SEQ, HDR_LEN, PAYLOAD, TRAILER} state_t;
`else
   typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_SEQ, HDR_LEN, PAYLOAD} state_t;
`endif

   state_t            state, state_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_next;
   logic [DATA_W-1:0] plen, remaining, pkt_len;
   logic              flush_pend;
   logic              push, pop, adv, start_full, start_flush, consume, last_pop, seq_inc;

   // tx handshake: a word moves on any cycle with tx_readreq=1 and tx_empty=0.
   assign push        = rx_valid & ~rx_full;
   assign adv         = tx_readreq & ~tx_empty;
   assign pop         = adv & (state == PAYLOAD);
   assign last_pop    = pop & (remaining == DATA_W'(1));
   assign start_full  = (state == IDLE) & (count >= PKT_CNT);
   assign start_flush = (state == IDLE) & ~start_full & flush_pend & (count != '0);
   assign consume     = (state == IDLE) & ~start_full & flush_pend;
   assign pkt_len     = start_full ? DATA_W'(PKT_WORDS) : DATA_W'(count);

`ifdef STREAM_FRAMER_CRC_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_W-1:0] d);
      logic [15:0] r;
      r = c;
      for (int i = DATA_W - 1; i >= 0; i--)
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   assign seq_inc = adv & (state == TRAILER);

   always_ff @(posedge clk) begin
      if (rst)
         crc <= 16'hFFFF;
      else if (start_full | start_flush)
         crc <= 16'hFFFF;
      else if (pop)
         crc <= crc_step(crc, mem[rd_ptr]);
   end
`else
   assign seq_inc = last_pop;
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= rx_data;
   end

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
   end

   // rx_full is registered, so a drop is decided on last cycle's count even if a pop happens now.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rx_full   <= 1'b0;
         ovf_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count   <= count_next;
         rx_full <= (count_next == FULL_CNT);
         if (rx_valid && rx_full && (ovf_count != 16'hFFFF))
            ovf_count <= ovf_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_pend <= 1'b0;
         plen       <= '0;
         remaining  <= '0;
         seq        <= '0;
      end else begin
         flush_pend <= rx_flush | (flush_pend & ~consume);
         if (start_full | start_flush) begin
            plen      <= pkt_len;
            remaining <= pkt_len;
         end else if (pop) begin
            remaining <= remaining - DATA_W'(1);
         end
         if (seq_inc)
            seq <= seq + DATA_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start_full | start_flush) state_next = HDR_SYNC;
         HDR_SYNC: if (adv) state_next = HDR_SEQ;
         HDR_SEQ:  if (adv) state_next = HDR_LEN;
         HDR_LEN:  if (adv) state_next = PAYLOAD;
`ifdef STREAM_FRAMER_CRC_EN
         PAYLOAD:  if (last_pop) state_next = TRAILER;
         TRAILER:  if (adv) state_next = IDLE;
`else
         PAYLOAD:  if (last_pop) state_next = IDLE;
`endif
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_empty = (state == IDLE);
      tx_data  = '0;
      case (state)
         HDR_SYNC: tx_data = DATA_W'(SYNC_WORD);
         HDR_SEQ:  tx_data = seq;
         HDR_LEN:  tx_data = plen;
         PAYLOAD:  tx_data = mem[rd_ptr];
`ifdef STREAM_FRAMER_CRC_EN
         TRAILER:  tx_data = DATA_W'(crc);
`endif
         default:  tx_data = '0;
      endcase
   end
endmodule

// File: tb/tb_stream_framer.sv
// Directed packet tests plus a randomized run scored against a queue-based packet model.
// Honours STREAM_FRAMER_CRC_EN by appending the expected trailer word to every packet.
module tb_stream_framer;
   localparam int DEPTH = 8;
   localparam int PKT   = 4;
`ifdef STREAM_FRAMER_CRC_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, rx_valid, rx_flush, tx_readreq;
   logic        rx_full, tx_empty;
   logic [15:0] rx_data, tx_data, ovf_count, seq;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   // reference model state for the random phase
   logic [15:0] m_fifo[$];
   logic [15:0] pkt_q[$];
   int          pkt_pos, pkt_plen, pkts_done, cnt_before, bub, phase, rq_pct;
   bit          busy, busy_now, m_fp, m_full, consume, saw;
   logic [15:0] m_ovf, m_seq, stall_word;

   stream_framer #(.DATA_W(16), .DEPTH(DEPTH), .PKT_WORDS(PKT), .SYNC_WORD(16'hA55A)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_full(rx_full),
      .rx_flush(rx_flush), .tx_readreq(tx_readreq), .tx_data(tx_data), .tx_empty(tx_empty),
      .ovf_count(ovf_count), .seq(seq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
         else              r = r << 1;
      end
      return r;
   endfunction

   // expected packet with consecutive payload words first, first+1, ...
   task automatic build_pkt(input logic [15:0] s, input int plen, input logic [15:0] first);
      logic [15:0] c, w;
      c = 16'hFFFF;
      exp_q = {};
      exp_q.push_back(16'hA55A);
      exp_q.push_back(s);
      exp_q.push_back(16'(plen));
      for (int i = 0; i < plen; i++) begin
         w = first + 16'(i);
         exp_q.push_back(w);
         c = crc16(c, w);
      end
      if (TRL == 1) exp_q.push_back(c);
   endtask

   task automatic push_word(input logic [15:0] w);
      rx_valid = 1'b1;
      rx_data  = w;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      rx_flush = 1'b1;
      @(negedge clk);
      rx_flush = 1'b0;
   endtask

   task automatic collect(input int n, output int bubbles);
      int got, guard;
      got = 0;
      guard = 0;
      bubbles = 0;
      tx_readreq = 1'b1;
      while (got < n && guard < 400) begin
         if (!tx_empty) begin
            got_q.push_back(tx_data);
            got++;
         end else if (got > 0) begin
            bubbles++;
         end
         guard++;
         @(negedge clk);
      end
      tx_readreq = 1'b0;
      check("collect_count", got, n);
   endtask

   task automatic compare_pkt(input string tag);
      int n;
      check({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      got_q = {};
   endtask

   task automatic model_start(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      pkt_q = {};
      pkt_q.push_back(16'hA55A);
      pkt_q.push_back(m_seq);
      pkt_q.push_back(16'(n));
      for (int i = 0; i < n; i++) begin
         pkt_q.push_back(m_fifo[i]);
         c = crc16(c, m_fifo[i]);
      end
      if (TRL == 1) pkt_q.push_back(c);
      pkt_pos  = 0;
      pkt_plen = n;
      busy     = 1'b1;
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_flush = 1'b0; tx_readreq = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_empty", tx_empty, 1);
      check("rst_tx_data", tx_data, 0);
      check("rst_rx_full", rx_full, 0);
      check("rst_ovf", ovf_count, 0);
      check("rst_seq", seq, 0);
      rst = 1'b0;
      @(negedge clk);

      // full packet, continuous readreq
      tx_readreq = 1'b1;
      for (int i = 1; i <= 4; i++) push_word(16'(i));
      build_pkt(16'h0000, 4, 16'h0001);
      collect(PKT + 3 + TRL, bub);
      compare_pkt("pkt_full");
      check("pkt_full_bubbles", bub, 0);
      check("pkt_full_seq_after", seq, 1);
      check("pkt_full_gap", tx_empty, 1);

      // flush closes a short packet
      push_word(16'h0005);
      push_word(16'h0006);
      pulse_flush();
      build_pkt(16'h0001, 2, 16'h0005);
      collect(2 + 3 + TRL, bub);
      compare_pkt("pkt_short");
      check("pkt_short_seq_after", seq, 2);

      // flush on empty FIFO emits nothing and is not remembered
      pulse_flush();
      saw = 1'b0;
      repeat (8) begin if (!tx_empty) saw = 1'b1; @(negedge clk); end
      check("flush_empty_no_pkt", saw, 0);
      push_word(16'h0099);
      saw = 1'b0;
      repeat (8) begin if (!tx_empty) saw = 1'b1; @(negedge clk); end
      check("flush_pend_cleared", saw, 0);
      for (int i = 0; i < 3; i++) push_word(16'h009A + 16'(i));
      build_pkt(16'h0002, 4, 16'h0099);
      collect(PKT + 3 + TRL, bub);
      compare_pkt("pkt_after_flush");

      // overflow with tx stalled, then mid-payload stall
      for (int i = 0; i < 10; i++) push_word(16'h0007 + 16'(i));
      check("ovf_rx_full", rx_full, 1);
      check("ovf_count", ovf_count, 2);
      build_pkt(16'h0003, 4, 16'h0007);
      collect(4, bub);
      stall_word = exp_q[4];
      repeat (5) begin
         check("stall_data", tx_data, stall_word);
         check("stall_not_empty", tx_empty, 0);
         @(negedge clk);
      end
      collect(PKT + 3 + TRL - 4, bub);
      compare_pkt("ovf_pkt1");
      build_pkt(16'h0004, 4, 16'h000B);
      collect(PKT + 3 + TRL, bub);
      compare_pkt("ovf_pkt2");
      check("ovf_rx_full_clear", rx_full, 0);
      check("ovf_count_hold", ovf_count, 2);

      // reset mid-payload abandons the packet and empties the FIFO
      for (int i = 0; i < 4; i++) push_word(16'h0021 + 16'(i));
      exp_q = {16'hA55A, 16'h0005, 16'h0004, 16'h0021, 16'h0022};
      collect(5, bub);
      compare_pkt("pre_rst");
      rst = 1'b1; rx_valid = 1'b1; rx_data = 16'h0077;
      @(negedge clk);
      check("midrst_tx_empty", tx_empty, 1);
      check("midrst_tx_data", tx_data, 0);
      check("midrst_rx_full", rx_full, 0);
      check("midrst_ovf", ovf_count, 0);
      check("midrst_seq", seq, 0);
      rst = 1'b0; rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) push_word(16'h0031 + 16'(i));
      build_pkt(16'h0000, 4, 16'h0031);
      collect(PKT + 3 + TRL, bub);
      compare_pkt("post_rst");

      // randomized traffic against the packet model
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_fifo = {}; pkt_q = {};
      busy = 1'b0; m_fp = 1'b0; m_full = 1'b0; m_ovf = '0; m_seq = '0;
      pkts_done = 0; pkt_pos = 0; pkt_plen = 0;
      for (int cyc = 0; cyc < 60000 && pkts_done < 1000; cyc++) begin
         check("rnd_tx_empty", tx_empty, !busy);
         if (busy) check("rnd_tx_data", tx_data, pkt_q[0]);
         check("rnd_rx_full", rx_full, m_full);
         check("rnd_ovf", ovf_count, m_ovf);
         check("rnd_seq", seq, m_seq);

         phase  = (cyc / 300) % 3;
         rq_pct = (phase == 0) ? 70 : (phase == 1) ? 15 : 95;
         rx_valid   = ($urandom_range(0, 99) < 55);
         rx_data    = 16'($urandom);
         rx_flush   = ($urandom_range(0, 24) == 0);
         tx_readreq = ($urandom_range(0, 99) < rq_pct);

         busy_now   = busy;
         cnt_before = m_fifo.size();
         consume    = 1'b0;
         if (busy_now && tx_readreq) begin
            if (pkt_pos >= 3 && pkt_pos < 3 + pkt_plen) void'(m_fifo.pop_front());
            void'(pkt_q.pop_front());
            pkt_pos++;
            if (pkt_q.size() == 0) begin
               busy = 1'b0;
               m_seq = m_seq + 16'd1;
               pkts_done++;
            end
         end
         if (!busy_now) begin
            if (cnt_before >= PKT) begin
               model_start(PKT);
            end else if (m_fp && cnt_before > 0) begin
               model_start(cnt_before);
               consume = 1'b1;
            end else if (m_fp) begin
               consume = 1'b1;
            end
         end
         m_fp = rx_flush | (m_fp & !consume);
         if (rx_valid) begin
            if (!m_full) m_fifo.push_back(rx_data);
            else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
         end
         m_full = (m_fifo.size() == DEPTH);
         @(negedge clk);
      end
      rx_valid = 1'b0; rx_flush = 1'b0; tx_readreq = 1'b0;
      check("rnd_pkts_done", pkts_done >= 1000, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
